data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory slave that answers the core's load/store port. It accepts one request at a time over the valid/yumi request handshake and performs the byte or word access on a local byte-addressed memory. After a fixed latency it returns a response over the valid/yumi response handshake, and holds it until the core acknowledges. It sits between `core.to_mem_o`/`data_mem_addr` and `core.from_mem_i`, and is the memory-side end of that interface.

## Interface
- `addr_width_p`, 12: byte-address width; capacity is 2^addr_width_p bytes, held as 2^(addr_width_p-2) 32-bit words.
- `latency_p`, 2: cycles from request accept to response valid; legal range 1..15.
- `clk`  in  1  clock.
- `n_reset`  in  1  reset, synchronous, active-low; clock clk.
- `to_mem_i`  in  mem_in_s  core request: write_data, valid, wen, byte_not_word, yumi (response ack).
- `addr_i`  in  32  byte address, sampled at accept.
- `from_mem_o`  out  mem_out_s  read_data (32), valid (response valid), yumi (request accept).
- `err_o`  out  1  sticky out-of-range flag (see Configuration).
- `busy_o`  out  1  high whenever the state is not IDLE.

## Operation
- State machine: IDLE, WAIT, RESP.
- IDLE:
  - `from_mem_o.yumi` = `to_mem_i.valid`, combinational, single cycle.
  - On accept, the access executes at the clock edge, the counter loads latency_p-1, and the state becomes WAIT. If latency_p==1, the state goes directly to RESP.
- Store (wen=1):
  - Word store writes write_data to word addr_i[addr_width_p-1:2]; addr_i[1:0] is ignored.
  - Byte store writes write_data[7:0] to lane addr_i[1:0], little-endian. Other lanes are unchanged.
  - read_data returns 0.
- Load (wen=0):
  - Word load returns the full word.
  - Byte load returns the selected lane, zero-extended.
  - read_data is registered at accept and stays stable until the response completes.
- WAIT: the counter decrements each cycle. When it reaches 0, the next state is RESP. Request valid is ignored.
- RESP:
  - `from_mem_o.valid`=1.
  - When `to_mem_i.yumi`=1, the response completes and the next state is IDLE. valid drops the following cycle.
  - Request valid is ignored; a new accept is not possible in the same cycle as a response yumi.
- Stores and loads both produce a response, because the core waits for valid to commit every memory operation.
- `to_mem_i.yumi` is ignored outside RESP.
- Reset:
  - State returns to IDLE. valid=0, yumi=0 (combinationally gated), read_data=0, err_o=0, busy_o=0.
  - Memory contents are not cleared.
  - A reset mid-operation abandons the request. A store already accepted remains written.

## Timing
- Accept happens in cycle T, when valid=1 in IDLE and yumi=1 in the same cycle.
- Response valid rises in cycle T+latency_p.
- The earliest completion is cycle T+latency_p, when the core's yumi is high in that same cycle.
- The earliest next accept is cycle T+latency_p+1.
- Back-to-back throughput is one request per latency_p+1 cycles.
- A stored word is visible to a load accepted in cycle T+1 or later.

## Configuration
- `DMEM_RANGE_CHECK_EN` defined:
  - An accepted request with addr_i[31:addr_width_p] != 0 sets err_o, which stays sticky until reset.
  - An out-of-range store is suppressed.
  - An out-of-range load returns 32'h0.
  - The handshake still completes normally.
- `DMEM_RANGE_CHECK_EN` undefined:
  - High address bits are dropped, so accesses alias modulo 2^addr_width_p.
  - err_o is tied 0.

## Test plan
- Reset: hold n_reset=0 for 3 cycles while valid=1 -> yumi=0, valid=0, read_data=0, busy_o=0 throughout.
- Word store then load, latency_p=2: store 32'hCAFEF00D at 0x40, accepted cycle T -> valid at T+2; assert core yumi at T+2. Load 0x40 accepted at T+3 -> valid at T+5 with read_data=32'hCAFEF00D.
- Byte lanes: after the word above, byte-store 8'h5A at 0x42 -> word load of 0x40 returns 32'hCA5AF00D; byte load of 0x43 returns 32'h000000CA.
- Response back-pressure: hold core yumi=0 for 6 cycles in RESP -> valid and read_data remain stable. Request valid=1 during that window gets no yumi. After core yumi pulses, the state is IDLE and the next accept occurs one cycle later.
- Latency sweep: latency_p=1 -> valid at T+1; latency_p=15 -> valid at T+15. busy_o is high from T+1 until the completion edge.
- Range check (macro defined, addr_width_p=12): store to 0x1000 -> err_o=1 after the accept edge, memory word 0 is unchanged, and the response still completes. Without the macro, the same store writes word 0 and err_o stays 0.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Load/store bus between the core and data_mem_responder: request struct and
// byte address from the core, response struct back to it.
package data_mem_pkg;
  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;
endpackage

interface data_mem_responder_if;
  import data_mem_pkg::*;

  mem_in_s     to_mem_i;
  logic [31:0] addr_i;
  mem_out_s    from_mem_o;

  modport master (output to_mem_i, output addr_i, input from_mem_o);
  modport slave  (input to_mem_i, input addr_i, output from_mem_o);
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory slave with fixed response latency.
// Optional DMEM_RANGE_CHECK_EN: flag and suppress accesses above 2^addr_width_p.
module data_mem_responder #(
  parameter int addr_width_p = 12,
  parameter int latency_p    = 2
) (
  input  logic                 clk,
  input  logic                 n_reset,
  data_mem_responder_if.slave  bus,
  output logic                 err_o,
  output logic                 busy_o
);
  localparam int word_w_lp = addr_width_p - 2;
  localparam int words_lp  = 2 ** word_w_lp;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] read_data_reg, read_data_next;
  logic        err_reg, err_next;

  logic [31:0] mem [words_lp];

  logic                 accept;
  logic                 in_range;
  logic                 store_go;
  logic [word_w_lp-1:0] word_idx;
  logic [1:0]           lane;
  logic [3:0]           lane_we;
  logic [7:0]           lane_data [4];
  logic [31:0]          rd_word;
  logic [7:0]           rd_byte;

  assign word_idx = bus.addr_i[addr_width_p-1:2];
  assign lane     = bus.addr_i[1:0];
  assign accept   = n_reset && (state_reg == IDLE) && bus.to_mem_i.valid;

`ifdef DMEM_RANGE_CHECK_EN
  assign in_range = (bus.addr_i[31:addr_width_p] == '0);
`else
  // High address bits alias; nothing beyond the low addr_width_p bits matters.
  logic unused_high_addr;
  assign unused_high_addr = ^bus.addr_i[31:addr_width_p];
  assign in_range = 1'b1;
`endif

  assign store_go = accept && bus.to_mem_i.wen && in_range;

  // Byte-enable per lane: a byte store lands on one lane, a word store on all four.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_we[gi]   = store_go && (!bus.to_mem_i.byte_not_word || (lane == 2'(gi)));
    assign lane_data[gi] = bus.to_mem_i.byte_not_word ? bus.to_mem_i.write_data[7:0]
                                                      : bus.to_mem_i.write_data[8*gi +: 8];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) begin
        mem[word_idx][8*i +: 8] <= lane_data[i];
      end
    end
  end

  assign rd_word = mem[word_idx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    read_data_next = read_data_reg;
    err_next       = err_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          cnt_next   = 4'(latency_p - 1);
          state_next = (latency_p == 1) ? RESP : WAIT;
          if (bus.to_mem_i.wen || !in_range) begin
            read_data_next = '0;
          end else if (bus.to_mem_i.byte_not_word) begin
            read_data_next = {24'h0, rd_byte};
          end else begin
            read_data_next = rd_word;
          end
          if (!in_range) begin
            err_next = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (bus.to_mem_i.yumi) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      read_data_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      read_data_reg <= read_data_next;
      err_reg       <= err_next;
    end
  end

  assign bus.from_mem_o = '{read_data: read_data_reg,
                            valid:     n_reset && (state_reg == RESP),
                            yumi:      accept};
  assign err_o  = err_reg;
  assign busy_o = (state_reg != IDLE);
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a byte-array memory model;
// two extra instances measure latency at the 1 and 15 extremes.
module tb_data_mem_responder;
  localparam int          AW    = 12;
  localparam int          LAT   = 2;
  localparam logic [31:0] AMASK = 32'((1 << AW) - 1);

  logic clk     = 1'b0;
  logic n_reset = 1'b0;
  logic err, busy;
  int   n_checks = 0;
  int   n_fails  = 0;

  logic [7:0]  ref_mem [1 << AW];
  bit          ref_err = 1'b0;
  logic [31:0] exp_rd;

  always #5 clk = ~clk;

  data_mem_responder_if bus ();

  data_mem_responder #(.addr_width_p(AW), .latency_p(LAT)) dut (
    .clk(clk), .n_reset(n_reset), .bus(bus), .err_o(err), .busy_o(busy)
  );

  // Latency extremes: each instance stores then loads one word with the core always acking.
  for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
    localparam int SL = (gi == 0) ? 1 : 15;
    data_mem_responder_if sbus ();
    logic        s_err, s_busy;
    bit          done = 1'b0;
    int          meas_lat [2];
    logic [31:0] meas_rd [2];
    logic [31:0] s_wd;
    int          acc_bad  = 0;
    int          busy_bad = 0;
    int          tail_bad = 0;

    data_mem_responder #(.addr_width_p(AW), .latency_p(SL)) sdut (
      .clk(clk), .n_reset(n_reset), .bus(sbus), .err_o(s_err), .busy_o(s_busy)
    );

    initial begin
      sbus.to_mem_i      = '0;
      sbus.addr_i        = 32'h80;
      sbus.to_mem_i.yumi = 1'b1;
      s_wd               = $urandom;
      while (n_reset !== 1'b1) @(negedge clk);
      @(negedge clk);
      for (int op = 0; op < 2; op++) begin
        int k;
        sbus.to_mem_i.valid      = 1'b1;
        sbus.to_mem_i.wen        = (op == 0);
        sbus.to_mem_i.write_data = s_wd;
        #1 if (sbus.from_mem_o.yumi !== 1'b1) acc_bad++;
        @(negedge clk);
        sbus.to_mem_i.valid = 1'b0;
        k = 1;
        while (sbus.from_mem_o.valid !== 1'b1 && k < 40) begin
          if (s_busy !== 1'b1) busy_bad++;
          @(negedge clk);
          k++;
        end
        if (s_busy !== 1'b1) busy_bad++;
        meas_lat[op] = k;
        meas_rd[op]  = sbus.from_mem_o.read_data;
        @(negedge clk);
        if (sbus.from_mem_o.valid !== 1'b0 || s_busy !== 1'b0) tail_bad++;
        $display("sweep latency_p=%0d op=%0d measured=%0d rdata=%h", SL, op, k, meas_rd[op]);
      end
      done = 1'b1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Byte-granular reference: applies the access and returns the expected read_data.
  function automatic logic [31:0] model_access(input bit wen, input bit bnw,
                                               input logic [31:0] addr, input logic [31:0] wd);
    int b, base;
    bit oob;
    oob = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
    oob = ((addr & ~AMASK) != 0);
    if (oob) ref_err = 1'b1;
`endif
    b    = int'(addr & AMASK);
    base = b & ~3;
    if (oob) return 32'h0;
    if (wen) begin
      if (bnw) ref_mem[b] = wd[7:0];
      else for (int i = 0; i < 4; i++) ref_mem[base + i] = 8'(wd >> (8 * i));
      return 32'h0;
    end
    if (bnw) return {24'h0, ref_mem[b]};
    return {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
  endfunction

  // Starts and ends at a falling edge; leaves the bench one cycle after the accept edge.
  task automatic issue(input bit wen, input bit bnw, input logic [31:0] addr, input logic [31:0] wd);
    bus.to_mem_i.valid         = 1'b1;
    bus.to_mem_i.wen           = wen;
    bus.to_mem_i.byte_not_word = bnw;
    bus.to_mem_i.write_data    = wd;
    bus.addr_i                 = addr;
    #1 check_val("acc_yumi", 32'(bus.from_mem_o.yumi), 32'd1);
    @(posedge clk);
    exp_rd = model_access(wen, bnw, addr, wd);
    @(negedge clk);
    bus.to_mem_i.valid = 1'b0;
    check_val("err", 32'(err), 32'(ref_err));
  endtask

  task automatic wait_resp(input int hold, input bit pend, input bit early, output logic [31:0] rd);
    int k;
    k = 1;
    bus.to_mem_i.yumi = early;
    while (bus.from_mem_o.valid !== 1'b1 && k < 40) begin
      check_val("busy_wait", 32'(busy), 32'd1);
      @(negedge clk);
      k++;
    end
    check_val("latency", 32'(k), 32'(LAT));
    check_val("busy_resp", 32'(busy), 32'd1);
    for (int h = 0; h < hold; h++) begin
      bus.to_mem_i.yumi = 1'b0;
      if (pend) begin
        bus.to_mem_i.valid = 1'b1;
        bus.to_mem_i.wen   = 1'b0;
        bus.addr_i         = $urandom;
      end
      #1;
      check_val("hold_valid", 32'(bus.from_mem_o.valid), 32'd1);
      check_val("hold_rd", bus.from_mem_o.read_data, exp_rd);
      if (pend) check_val("no_acc_resp", 32'(bus.from_mem_o.yumi), 32'd0);
      @(negedge clk);
    end
    bus.to_mem_i.yumi = 1'b1;
    #1;
    check_val("resp_valid", 32'(bus.from_mem_o.valid), 32'd1);
    check_val("resp_rd", bus.from_mem_o.read_data, exp_rd);
    if (pend) check_val("no_acc_ack", 32'(bus.from_mem_o.yumi), 32'd0);
    rd = bus.from_mem_o.read_data;
    @(negedge clk);
    bus.to_mem_i.yumi = 1'b0;
    check_val("done_valid", 32'(bus.from_mem_o.valid), 32'd0);
    check_val("done_busy", 32'(busy), 32'd0);
  endtask

  task automatic txn(input bit wen, input bit bnw, input logic [31:0] addr, input logic [31:0] wd,
                     input int hold, input bit pend, input bit early, output logic [31:0] rd);
    issue(wen, bnw, addr, wd);
    wait_resp(hold, pend, early, rd);
    $display("txn %s %s addr=%h wdata=%h rdata=%h expect=%h hold=%0d",
             wen ? "store" : "load ", bnw ? "byte" : "word", addr, wd, rd, exp_rd, hold);
  endtask

  initial begin
    logic [31:0] rd, a, wd;
    bit          wen, bnw;
    int          c;
    bus.to_mem_i = '0;
    bus.addr_i   = '0;

    // Reset held with a pending request.
    n_reset            = 1'b0;
    bus.to_mem_i.valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_val("rst_yumi", 32'(bus.from_mem_o.yumi), 32'd0);
      check_val("rst_valid", 32'(bus.from_mem_o.valid), 32'd0);
      check_val("rst_rd", bus.from_mem_o.read_data, 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_err", 32'(err), 32'd0);
    end
    bus.to_mem_i.valid = 1'b0;
    n_reset            = 1'b1;
    @(negedge clk);

    // Directed word/byte accesses and response back-pressure.
    txn(1'b1, 1'b0, 32'h40, 32'hCAFEF00D, 0, 1'b0, 1'b0, rd);
    check_val("st_rd", rd, 32'h0);
    txn(1'b0, 1'b0, 32'h40, 32'h0, 0, 1'b0, 1'b0, rd);
    check_val("ld_word", rd, 32'hCAFEF00D);
    txn(1'b1, 1'b1, 32'h42, 32'hFFFFFF5A, 1, 1'b0, 1'b1, rd);
    txn(1'b0, 1'b0, 32'h40, 32'h0, 0, 1'b0, 1'b0, rd);
    check_val("ld_patched", rd, 32'hCA5AF00D);
    txn(1'b0, 1'b1, 32'h43, 32'h0, 6, 1'b1, 1'b0, rd);
    check_val("ld_byte", rd, 32'h000000CA);
    txn(1'b0, 1'b0, 32'h40, 32'h0, 0, 1'b0, 1'b0, rd);
    check_val("ld_after_bp", rd, 32'hCA5AF00D);

    // Out-of-range store behaviour.
    txn(1'b1, 1'b0, 32'h0, 32'h11223344, 0, 1'b0, 1'b0, rd);
    txn(1'b1, 1'b0, 32'h1000, 32'h55667788, 0, 1'b0, 1'b0, rd);
    check_val("range_err", 32'(err), 32'(ref_err));
    txn(1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0, rd);
`ifdef DMEM_RANGE_CHECK_EN
    check_val("range_word0", rd, 32'h11223344);
`else
    check_val("range_word0", rd, 32'h55667788);
`endif

    // Fill a 16-word window, then random traffic over it with aliased high bits.
    for (int w = 0; w < 16; w++) txn(1'b1, 1'b0, 32'h100 + 32'(4 * w), $urandom, 0, 1'b0, 1'b0, rd);
    for (int i = 0; i < 60; i++) begin
      wen = 1'($urandom);
      bnw = 1'($urandom);
      wd  = $urandom;
      a   = (($urandom_range(0, 1) == 1) ? ($urandom & ~AMASK) : 32'h0) | (32'h100 + 32'($urandom_range(0, 63)));
      txn(wen, bnw, a, wd, $urandom_range(0, 3), (i < 59) ? 1'($urandom) : 1'b0, 1'($urandom), rd);
    end

    // Latency extremes from the side instances.
    c = 0;
    while (!(g_sweep[0].done && g_sweep[1].done) && c < 300) begin
      @(negedge clk);
      c++;
    end
    check_val("sweep_done", 32'(g_sweep[0].done && g_sweep[1].done), 32'd1);
    check_val("lat1_store", 32'(g_sweep[0].meas_lat[0]), 32'd1);
    check_val("lat1_load", 32'(g_sweep[0].meas_lat[1]), 32'd1);
    check_val("lat15_store", 32'(g_sweep[1].meas_lat[0]), 32'd15);
    check_val("lat15_load", 32'(g_sweep[1].meas_lat[1]), 32'd15);
    check_val("lat1_st_rd", g_sweep[0].meas_rd[0], 32'h0);
    check_val("lat1_ld_rd", g_sweep[0].meas_rd[1], g_sweep[0].s_wd);
    check_val("lat15_ld_rd", g_sweep[1].meas_rd[1], g_sweep[1].s_wd);
    check_val("sweep_acc", 32'(g_sweep[0].acc_bad + g_sweep[1].acc_bad), 32'd0);
    check_val("sweep_busy", 32'(g_sweep[0].busy_bad + g_sweep[1].busy_bad), 32'd0);
    check_val("sweep_tail", 32'(g_sweep[0].tail_bad + g_sweep[1].tail_bad), 32'd0);

    // Reset mid-operation: request abandoned, accepted store kept.
    issue(1'b1, 1'b0, 32'h104, 32'hA5A5_1234);
    n_reset = 1'b0;
    @(negedge clk);
    ref_err = 1'b0;
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_valid", 32'(bus.from_mem_o.valid), 32'd0);
    check_val("midrst_rd", bus.from_mem_o.read_data, 32'd0);
    check_val("midrst_err", 32'(err), 32'd0);
    n_reset = 1'b1;
    @(negedge clk);
    txn(1'b0, 1'b0, 32'h104, 32'h0, 0, 1'b0, 1'b0, rd);
    check_val("midrst_kept", rd, 32'hA5A5_1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
